// File: rtl/mem_access_unit.sv
// MEM-stage SRAM access controller and MEM/WB pipeline register.
// Optional misaligned-access trap enabled by defining MEM_ALIGN_CHECK_EN.
module mem_access_unit #(
  parameter int ADDR_W      = 11,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              memRead_mem,
  input  logic              memWrite_mem,
  input  logic              regWrite_mem,
  input  logic              memToReg_mem,
  input  logic [31:0]       aluResult_mem,
  input  logic [31:0]       writeDataToSRAM_mem,
  input  logic [4:0]        writeRegOut_mem,
  input  logic [31:0]       sram_rdata,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [31:0]       sram_wdata,
  output logic              sram_ce_n,
  output logic              sram_oe_n,
  output logic              sram_we_n,
  output logic              stall_mem,
  output logic [31:0]       readData_wb,
  output logic [31:0]       aluResult_wb,
  output logic [4:0]        writeRegOut_wb,
  output logic              regWrite_wb,
  output logic              memToReg_wb,
  output logic              misalign_mem
);

  typedef enum logic [2:0] {
    IDLE,
    RD,
    WR_SETUP,
    WR_PULSE,
    DONE
  } state_t;

  localparam logic [3:0] WC = WAIT_CYCLES[3:0];

  state_t      state, state_n;
  logic [3:0]  cnt, cnt_n;
  logic [31:0] rdata_q;
  logic        stall, capture;
  logic        mis, req;

`ifdef MEM_ALIGN_CHECK_EN
  assign mis = !reset && (state == IDLE)
             && (memRead_mem || memWrite_mem)
             && (aluResult_mem[1:0] != 2'b00);
`else
  assign mis = 1'b0;
`endif

  assign misalign_mem = mis;
  assign req = (memRead_mem || memWrite_mem) && !mis;

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    stall   = 1'b0;
    capture = 1'b0;
    unique case (state)
      IDLE: begin
        // a store takes priority over a simultaneous load
        if (req && memWrite_mem) begin
          stall   = 1'b1;
          state_n = WR_SETUP;
        end else if (req) begin
          stall   = 1'b1;
          state_n = RD;
          cnt_n   = WC;
        end
      end
      RD: begin
        stall = 1'b1;
        cnt_n = cnt - 4'd1;
        if (cnt == 4'd1) begin
          capture = 1'b1;
          state_n = DONE;
        end
      end
      WR_SETUP: begin
        stall   = 1'b1;
        state_n = WR_PULSE;
        cnt_n   = WC;
      end
      WR_PULSE: begin
        stall = 1'b1;
        cnt_n = cnt - 4'd1;
        if (cnt == 4'd1) state_n = DONE;
      end
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign stall_mem = stall && !reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      cnt            <= 4'd0;
      rdata_q        <= 32'd0;
      sram_ce_n      <= 1'b1;
      sram_oe_n      <= 1'b1;
      sram_we_n      <= 1'b1;
      sram_addr      <= '0;
      sram_wdata     <= 32'd0;
      readData_wb    <= 32'd0;
      aluResult_wb   <= 32'd0;
      writeRegOut_wb <= 5'd0;
      regWrite_wb    <= 1'b0;
      memToReg_wb    <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (capture) rdata_q <= sram_rdata;
      // strobes follow the next state so they leave a flop cleanly
      sram_ce_n <= !(state_n == RD || state_n == WR_SETUP
                  || state_n == WR_PULSE);
      sram_oe_n <= (state_n != RD);
      sram_we_n <= (state_n != WR_PULSE);
      if (state_n == RD || state_n == WR_SETUP)
        sram_addr <= aluResult_mem[ADDR_W+1:2];
      if (state_n == WR_SETUP)
        sram_wdata <= writeDataToSRAM_mem;
      if (stall) begin
        regWrite_wb <= 1'b0;
      end else begin
        regWrite_wb    <= regWrite_mem && !mis;
        memToReg_wb    <= memToReg_mem;
        aluResult_wb   <= aluResult_mem;
        writeRegOut_wb <= writeRegOut_mem;
        readData_wb    <= (state == DONE) ? rdata_q : 32'd0;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed table, corner sequences and
// random instructions checked against a transaction-level memory model.
module tb_mem_access_unit;

  localparam int AW = 11;
  localparam int W  = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        memRead_mem, memWrite_mem;
  logic        regWrite_mem, memToReg_mem;
  logic [31:0] aluResult_mem, writeDataToSRAM_mem;
  logic [4:0]  writeRegOut_mem;
  logic [31:0] sram_rdata;
  logic [AW-1:0] sram_addr;
  logic [31:0] sram_wdata;
  logic        sram_ce_n, sram_oe_n, sram_we_n;
  logic        stall_mem;
  logic [31:0] readData_wb, aluResult_wb;
  logic [4:0]  writeRegOut_wb;
  logic        regWrite_wb, memToReg_wb;
  logic        misalign_mem;

  int tests = 0;
  int fails = 0;

  mem_access_unit #(.ADDR_W(AW), .WAIT_CYCLES(W)) dut (
    .clk(clk),
    .reset(reset),
    .memRead_mem(memRead_mem),
    .memWrite_mem(memWrite_mem),
    .regWrite_mem(regWrite_mem),
    .memToReg_mem(memToReg_mem),
    .aluResult_mem(aluResult_mem),
    .writeDataToSRAM_mem(writeDataToSRAM_mem),
    .writeRegOut_mem(writeRegOut_mem),
    .sram_rdata(sram_rdata),
    .sram_addr(sram_addr),
    .sram_wdata(sram_wdata),
    .sram_ce_n(sram_ce_n),
    .sram_oe_n(sram_oe_n),
    .sram_we_n(sram_we_n),
    .stall_mem(stall_mem),
    .readData_wb(readData_wb),
    .aluResult_wb(aluResult_wb),
    .writeRegOut_wb(writeRegOut_wb),
    .regWrite_wb(regWrite_wb),
    .memToReg_wb(memToReg_wb),
    .misalign_mem(misalign_mem)
  );

  always #5 clk = ~clk;

  // asynchronous SRAM behaviour
  logic [31:0] sram [0:(1<<AW)-1];
  assign sram_rdata = (!sram_ce_n && !sram_oe_n)
                    ? sram[sram_addr] : 32'hBAD0_BAD0;
  always @(posedge clk)
    if (!sram_ce_n && !sram_we_n) sram[sram_addr] <= sram_wdata;

  // reference: word memory and the last loaded value
  logic [31:0] ref_mem [int];
  logic [31:0] last_load;

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    int idx = int'(a[AW+1:2]);
    return ref_mem.exists(idx) ? ref_mem[idx] : 32'd0;
  endfunction

  function automatic bit is_mis(input logic rd, wr,
                                input logic [31:0] a);
`ifdef MEM_ALIGN_CHECK_EN
    return (rd || wr) && (a[1:0] != 2'b00);
`else
    return 1'b0;
`endif
  endfunction

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 of the next instruction slot.
  task automatic run_instr(input logic rd, wr, rw, m2r,
                           input logic [31:0] alu, wd,
                           input logic [4:0] rdst,
                           input int exp_stall,
                           input logic [31:0] exp_rdata,
                           input string tag);
    int stalls = 0, oe_low = 0, we_low = 0, ce_low = 0;
    bit ok = 1, done = 0, mis;
    logic [AW-1:0] ea;
    ea  = alu[AW+1:2];
    mis = is_mis(rd, wr, alu);
    memRead_mem = rd;
    memWrite_mem = wr;
    regWrite_mem = rw;
    memToReg_mem = m2r;
    aluResult_mem = alu;
    writeDataToSRAM_mem = wd;
    writeRegOut_mem = rdst;
    for (int b = 0; b < 40 && !done; b++) begin
      #1;
      if (stall_mem) begin
        stalls++;
        if (!sram_oe_n) oe_low++;
        if (!sram_we_n) we_low++;
        if (!sram_ce_n) begin
          ce_low++;
          if (sram_addr !== ea) ok = 0;
          if (wr && sram_wdata !== wd) ok = 0;
        end
        @(posedge clk); #1;
      end else begin
        done = 1;
        check({tag, " misalign"}, 32'(misalign_mem), 32'(mis));
        check({tag, " ce_n"}, 32'(sram_ce_n), 32'd1);
        if (exp_stall > 0) begin
          check({tag, " done addr"}, 32'(sram_addr), 32'(ea));
          if (wr) check({tag, " done wdata"}, sram_wdata, wd);
        end
        @(posedge clk); #1;
        check({tag, " regWrite_wb"}, 32'(regWrite_wb),
              32'(rw && !mis));
        check({tag, " memToReg_wb"}, 32'(memToReg_wb), 32'(m2r));
        check({tag, " aluResult_wb"}, aluResult_wb, alu);
        check({tag, " writeReg_wb"}, 32'(writeRegOut_wb), 32'(rdst));
        check({tag, " readData_wb"}, readData_wb, exp_rdata);
      end
    end
    if (!done) begin
      tests++;
      fails++;
      $display("FAIL %s timeout: stall still %0d expected 0", tag,
               stall_mem);
      return;
    end
    check({tag, " stall cycles"}, 32'(stalls), 32'(exp_stall));
    check({tag, " addr/wdata stable"}, 32'(ok), 32'd1);
    if (exp_stall > 0 && wr) begin
      check({tag, " we_n low"}, 32'(we_low), 32'(W));
      check({tag, " oe_n low"}, 32'(oe_low), 32'd0);
      check({tag, " ce_n low"}, 32'(ce_low), 32'(W + 1));
    end else if (exp_stall > 0) begin
      check({tag, " oe_n low"}, 32'(oe_low), 32'(W));
      check({tag, " we_n low"}, 32'(we_low), 32'd0);
    end
  endtask

  // transaction model of the unit used for random stimulus
  task automatic run_model(input logic rd, wr, rw, m2r,
                           input logic [31:0] alu, wd,
                           input logic [4:0] rdst,
                           input string tag);
    int es;
    logic [31:0] er;
    bit mis = is_mis(rd, wr, alu);
    if (mis || !(rd || wr)) begin
      es = 0;
      er = 32'd0;
    end else if (wr) begin
      es = W + 2;
      er = last_load;
    end else begin
      es = W + 1;
      er = ref_rd(alu);
      last_load = er;
    end
    run_instr(rd, wr, rw, m2r, alu, wd, rdst, es, er, tag);
    if (wr && !mis) ref_mem[int'(alu[AW+1:2])] = wd;
  endtask

  typedef struct {
    logic        rd, wr, rw, m2r;
    logic [31:0] alu, wd;
    logic [4:0]  rdst;
    int          exp_stall;
    logic [31:0] exp_rdata;
    string       tag;
  } vec_t;

  vec_t vt [7];

  initial begin
    vt[0] = '{0, 0, 1, 0, 32'h55, 32'h0, 5'd7, 0, 32'h0, "alu"};
    vt[1] = '{0, 1, 0, 0, 32'h8, 32'h12345678, 5'd0, 4, 32'h0,
              "st8"};
    vt[2] = '{1, 0, 1, 1, 32'h40, 32'h0, 5'd3, 3, 32'hDEADBEEF,
              "ld40"};
    vt[3] = '{1, 0, 1, 1, 32'h8, 32'h0, 5'd4, 3, 32'h12345678,
              "ld8"};
    vt[4] = '{1, 1, 0, 0, 32'h0, 32'hA5A5A5A5, 5'd9, 4,
              32'h12345678, "rdwr0"};
    vt[5] = '{1, 0, 1, 1, 32'h0, 32'h0, 5'd5, 3, 32'hA5A5A5A5,
              "ld0"};
    vt[6] = '{0, 0, 0, 1, 32'hCAFE, 32'h0, 5'd31, 0, 32'h0, "nop"};

    for (int i = 0; i < (1 << AW); i++) sram[i] = 32'd0;
    sram[16] = 32'hDEADBEEF;
    ref_mem[16] = 32'hDEADBEEF;
    ref_mem[2] = 32'h12345678;
    ref_mem[0] = 32'hA5A5A5A5;

    reset = 1'b1;
    memRead_mem = 1'b1;
    memWrite_mem = 1'b0;
    regWrite_mem = 1'b1;
    memToReg_mem = 1'b1;
    aluResult_mem = 32'h40;
    writeDataToSRAM_mem = 32'h0;
    writeRegOut_mem = 5'd1;
    repeat (2) @(posedge clk);
    #1;
    check("rst stall", 32'(stall_mem), 32'd0);
    check("rst strobes", {29'd0, sram_ce_n, sram_oe_n, sram_we_n},
          32'd7);
    check("rst addr", 32'(sram_addr), 32'd0);
    check("rst wdata", sram_wdata, 32'd0);
    check("rst wb", {readData_wb ^ aluResult_wb, 32'(writeRegOut_wb)}
          == 64'd0 ? 32'(regWrite_wb | memToReg_wb) : 32'hFFFF,
          32'd0);
    check("rst misalign", 32'(misalign_mem), 32'd0);
    reset = 1'b0;
    memRead_mem = 1'b0;
    @(posedge clk); #1;

    last_load = 32'd0;
    foreach (vt[i])
      run_instr(vt[i].rd, vt[i].wr, vt[i].rw, vt[i].m2r, vt[i].alu,
                vt[i].wd, vt[i].rdst, vt[i].exp_stall,
                vt[i].exp_rdata, vt[i].tag);
    last_load = 32'hA5A5A5A5;

`ifdef MEM_ALIGN_CHECK_EN
    run_instr(1, 0, 1, 1, 32'h41, 32'h0, 5'd2, 0, 32'h0, "mis41");
`else
    run_instr(1, 0, 1, 1, 32'h41, 32'h0, 5'd2, W + 1,
              32'hDEADBEEF, "ld41");
    last_load = 32'hDEADBEEF;
`endif

    // reset in the middle of a store pulse
    memRead_mem = 1'b0;
    memWrite_mem = 1'b1;
    regWrite_mem = 1'b0;
    aluResult_mem = 32'd400;
    writeDataToSRAM_mem = 32'h0BAD0BAD;
    begin
      bit seen = 0;
      for (int b = 0; b < 20 && !seen; b++) begin
        @(posedge clk); #1;
        if (!sram_we_n) seen = 1;
      end
      check("rst-mid reached pulse", 32'(seen), 32'd1);
    end
    reset = 1'b1;
    #1;
    check("rst-mid stall", 32'(stall_mem), 32'd0);
    @(posedge clk); #1;
    check("rst-mid we_n", 32'(sram_we_n), 32'd1);
    check("rst-mid ce_n", 32'(sram_ce_n), 32'd1);
    check("rst-mid readData_wb", readData_wb, 32'd0);
    check("rst-mid aluResult_wb", aluResult_wb, 32'd0);
    check("rst-mid ctl_wb", {25'd0, writeRegOut_wb, regWrite_wb,
          memToReg_wb}, 32'd0);
    check("rst-mid stall high", 32'(stall_mem), 32'd0);
    reset = 1'b0;
    memWrite_mem = 1'b0;
    @(posedge clk); #1;
    run_instr(1, 0, 1, 1, 32'h8, 32'h0, 5'd6, W + 1, 32'h12345678,
              "post-rst ld");
    last_load = 32'h12345678;

    for (int n = 0; n < 200; n++) begin
      int k = $urandom_range(0, 3);
      logic [31:0] a;
      a = {$urandom} & 32'hFFFF_F000;
      a[5:2] = 4'($urandom_range(0, 15));
      a[1:0] = 2'($urandom_range(0, 3));
      unique case (k)
        0: run_model(0, 0, 1'($urandom), 1'($urandom), a, $urandom,
                     5'($urandom), "rnd alu");
        1: run_model(1, 0, 1, 1, a, $urandom, 5'($urandom), "rnd ld");
        2: run_model(0, 1, 0, 0, a, $urandom, 5'($urandom), "rnd st");
        default: run_model(1, 1, 0, 0, a, $urandom, 5'($urandom),
                           "rnd rdwr");
      endcase
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
